// File: rtl/mul16_pkg.sv
// Shared definitions for the 16-bit shift-and-add multiplier and its bench.
// Holds the FSM state encodings and the fixed iteration count.
package mul16_pkg;

  localparam int unsigned MUL_W     = 16;
  localparam int unsigned MUL_ITERS = 16;
  localparam logic [3:0]  LAST_COUNT = 4'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_if.sv
// Request/result bundle between a multiply requester and mul16.
// start/a/b flow toward the multiplier; out/busy/done flow back.
interface mul16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        busy;
  logic        done;

  modport slave  (input  start, a, b, output out, busy, done);
  modport master (output start, a, b, input  out, busy, done);
endinterface

// File: rtl/Add16.sv
// 16-bit ripple-carry adder; carry out of the top bit is dropped (mod 2^16).
// Purely combinational.
module Add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic c;

  always_comb begin
    sum_o = '0;
    c     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/mul16.sv
// Sequential 16x16 -> 16 unsigned multiplier: exactly 16 shift-and-add steps per operation,
// result in out with a one-cycle done pulse; start is ignored while busy.
module mul16
  import mul16_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  mul16_if.slave io
);

  state_t      state_q;
  logic [3:0]  count_q;
  logic [15:0] ma_q;
  logic [15:0] mb_q;
  logic [15:0] acc_q;
  logic [15:0] out_q;
  logic [15:0] sum;
  logic [15:0] acc_d;

  Add16 u_add (
    .a_i   (acc_q),
    .b_i   (ma_q),
    .sum_o (sum)
  );

  // Partial product is added only when the current multiplier LSB is set.
  assign acc_d = mb_q[0] ? sum : acc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.start) begin
            ma_q    <= io.a;
            mb_q    <= io.b;
            acc_q   <= '0;
            count_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          ma_q    <= ma_q << 1;
          mb_q    <= mb_q >> 1;
          count_q <= count_q + 4'd1;
          if (count_q == LAST_COUNT) begin
            out_q   <= acc_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.out  = out_q;
  assign io.busy = (state_q != ST_IDLE);
  assign io.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mul16.sv
// Directed bench for mul16: stimulus pushes expected products, a monitor checks each done pulse.
module tb_mul16;
  import mul16_pkg::*;

  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] sb[$];
  logic prev_done;

  mul16_if io ();

  mul16 dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial prev_done = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (io.done) begin
        check("done_width", {31'b0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got out=%0h, expected no result", io.out);
        end else begin
          check("product", {16'b0, io.out}, {16'b0, sb.pop_front()});
        end
      end
      prev_done = io.done;
    end
  end

  // Issue one op; verify busy length, done position and that out holds during RUN.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int          cyc;
    int          done_at;
    logic        held;
    logic [15:0] old;
    @(negedge clock);
    io.a     = a;
    io.b     = b;
    io.start = 1'b1;
    sb.push_back(exp);
    old = io.out;
    @(negedge clock);
    io.start = 1'b0;
    cyc      = 0;
    done_at  = 0;
    held     = 1'b1;
    while (io.busy && cyc < 40) begin
      cyc++;
      if (io.done) done_at = cyc;
      else if (io.out !== old) held = 1'b0;
      @(negedge clock);
    end
    check("busy_cycles", cyc, 17);
    check("done_cycle", done_at, 17);
    check("out_held_in_run", {31'b0, held}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (io.busy && cyc < 60) begin
      cyc++;
      @(negedge clock);
    end
    check(name, {31'b0, io.busy}, 32'd0);
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!io.done && cyc < 60);
    check(name, {31'b0, io.done}, 32'd1);
  endtask

  initial begin
    int gap;
    io.start = 1'b0;
    io.a     = '0;
    io.b     = '0;
    reset    = 1'b1;
    #1;
    check("rst_out",  {16'b0, io.out}, 32'd0);
    check("rst_busy", {31'b0, io.busy}, 32'd0);
    check("rst_done", {31'b0, io.done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op(16'd3, 16'd5, 16'd15);
    run_op(16'hFFFF, 16'hFFFF, 16'h0001);
    run_op(16'h0100, 16'h0100, 16'h0000);
    run_op(16'h0000, 16'h1234, 16'h0000);
    run_op(16'h1234, 16'h0000, 16'h0000);
    run_op(16'h8001, 16'h0003, 16'h8003);

    // Start pulse and operand change in RUN cycle 5 must not disturb 7*6.
    @(negedge clock);
    io.a = 16'd7; io.b = 16'd6; io.start = 1'b1;
    sb.push_back(16'd42);
    @(negedge clock);
    io.start = 1'b0;
    repeat (4) @(negedge clock);
    io.a = 16'd2; io.b = 16'd2; io.start = 1'b1;
    @(negedge clock);
    io.start = 1'b0; io.a = 16'hAAAA; io.b = 16'h5555;
    wait_idle("busy_timeout_mid_start");
    repeat (2) @(negedge clock);
    check("ignored_start_busy", {31'b0, io.busy}, 32'd0);
    check("hold_out_idle", {16'b0, io.out}, 32'd42);

    // Asynchronous abort at RUN cycle 8 of 100*100.
    @(negedge clock);
    io.a = 16'd100; io.b = 16'd100; io.start = 1'b1;
    @(negedge clock);
    io.start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_out",  {16'b0, io.out}, 32'd0);
    check("abort_busy", {31'b0, io.busy}, 32'd0);
    check("abort_done", {31'b0, io.done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op(16'd9, 16'd9, 16'd81);

    // start held high: back-to-back ops, one done every 18 cycles.
    @(negedge clock);
    io.a = 16'd3; io.b = 16'd4; io.start = 1'b1;
    sb.push_back(16'd12);
    wait_done("b2b_first_done", gap);
    io.a = 16'd5;
    sb.push_back(16'd20);
    wait_done("b2b_second_done", gap);
    io.start = 1'b0;
    check("b2b_period", gap, 18);
    wait_idle("busy_timeout_b2b");
    repeat (3) @(negedge clock);
    check("no_third_op", {31'b0, io.busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
